// File: rtl/mips_run_ctrl_if.sv
// Control/observation bundle between the run controller and its host (sim top or FPGA wrapper).
interface mips_run_ctrl_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             abort;
  logic             clear;
  logic [PC_W-1:0]  pc;
  logic             cpu_reset;
  logic             cpu_en;
  logic             running;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, abort, clear, pc,
    input  cpu_reset, cpu_en, running, done, status, cycle_count
  );

  modport slave (
    input  start, abort, clear, pc,
    output cpu_reset, cpu_en, running, done, status, cycle_count
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: sequences core reset, gates its clock enable,
// counts run cycles and ends the run on halt (stalled PC), timeout or abort.
module mips_run_ctrl #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned MAX_CYCLES  = 10000,
  parameter int unsigned STALL_LIMIT = 4,
  parameter bit          AUTO_START  = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mips_run_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_HALT    = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
  localparam logic [1:0] STAT_ABORT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]    pc_last_q, pc_last_d;
  logic               first_q, first_d;
  logic [1:0]         status_q, status_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               cpu_en_q, cpu_en_d;
  logic               running_q, running_d;
  logic               done_q, done_d;

  logic               pc_eq;
  logic               halt_hit;
  logic               timeout_hit;
  logic [CNT_W-1:0]   cycle_inc;
  logic [STALL_W-1:0] stall_inc;

  // State and counter registers; outputs are registered copies decoded from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      pc_last_q   <= '0;
      first_q     <= 1'b1;
      status_q    <= STAT_NONE;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      pc_last_q   <= pc_last_d;
      first_q     <= first_d;
      status_q    <= status_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counters and exit priority (abort > halt > timeout).
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    pc_last_d   = pc_last_q;
    first_d     = (state_q != ST_RUN);
    status_d    = status_q;

    cycle_inc   = cycle_cnt_q + CNT_W'(1);
    stall_inc   = stall_cnt_q + STALL_W'(1);
    pc_eq       = !first_q && (bus.pc == pc_last_q);
    halt_hit    = pc_eq && (stall_inc == STALL_W'(STALL_LIMIT));
    timeout_hit = (cycle_inc == CNT_W'(MAX_CYCLES));

    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (AUTO_START || bus.start) state_d = ST_RESET_HOLD;
      end
      ST_RESET_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          hold_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cycle_cnt_d = cycle_inc;
        pc_last_d   = bus.pc;
        stall_cnt_d = pc_eq ? stall_inc : '0;
        if (bus.abort) begin
          state_d  = ST_DONE;
          status_d = STAT_ABORT;
        end else if (halt_hit) begin
          state_d  = ST_DONE;
          status_d = STAT_HALT;
        end else if (timeout_hit) begin
          state_d  = ST_DONE;
          status_d = STAT_TIMEOUT;
        end
      end
      ST_DONE: begin
        if (bus.clear) begin
          state_d     = ST_IDLE;
          status_d    = STAT_NONE;
          cycle_cnt_d = '0;
          stall_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET_HOLD);
    cpu_en_d    = (state_d == ST_RUN);
    running_d   = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.cpu_en      = cpu_en_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: one auto-start instance (hold=3, timeout=20, stall=4)
// and one start-pulse instance.
module tb_mips_run_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_vec;
  int   n_fail;
  bit   seen_en;

  mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) ifa ();
  mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) ifb ();

  mips_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(3), .MAX_CYCLES(20), .STALL_LIMIT(4), .AUTO_START(1'b1)
  ) dut_a (
    .clk  (clk),
    .reset(rst_a),
    .bus  (ifa.slave)
  );

  mips_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(1), .MAX_CYCLES(20), .STALL_LIMIT(4), .AUTO_START(1'b0)
  ) dut_b (
    .clk  (clk),
    .reset(rst_b),
    .bus  (ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_state(input string tag, input logic en, input logic rs,
                             input logic dn, input logic [1:0] st, input logic [31:0] cnt);
    chk({tag, ".cpu_en"},    32'(ifa.cpu_en),    32'(en));
    chk({tag, ".cpu_reset"}, 32'(ifa.cpu_reset), 32'(rs));
    chk({tag, ".running"},   32'(ifa.running),   32'(en));
    chk({tag, ".done"},      32'(ifa.done),      32'(dn));
    chk({tag, ".status"},    32'(ifa.status),    32'(st));
    chk({tag, ".count"},     ifa.cycle_count,    cnt);
  endtask

  initial begin
    n_vec = 0; n_fail = 0; seen_en = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.clear = 1'b0; ifa.pc = '0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.clear = 1'b0; ifb.pc = '0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;

    // T1: reset values before any clock edge
    chk_a_state("t1_reset", 1'b0, 1'b1, 1'b0, 2'b00, 32'd0);
    step(); step();
    chk_a_state("t1_held", 1'b0, 1'b1, 1'b0, 2'b00, 32'd0);

    // T2: auto start, one IDLE edge then three RESET_HOLD cycles
    rst_a = 1'b0;
    step(); step(); step();
    chk_a_state("t2_hold", 1'b0, 1'b1, 1'b0, 2'b00, 32'd0);
    step();
    chk_a_state("t2_run", 1'b1, 1'b0, 1'b0, 2'b00, 32'd0);

    // T3: halt after four equal PC comparisons
    for (int i = 0; i < 5; i++) begin
      ifa.pc = 32'(32'h3000 + 4 * i);
      step();
    end
    step(); step(); step();
    chk_a_state("t3_pre", 1'b1, 1'b0, 1'b0, 2'b00, 32'd8);
    step();
    chk_a_state("t3_halt", 1'b0, 1'b0, 1'b1, 2'b01, 32'd9);

    ifa.clear = 1'b1;
    step();
    ifa.clear = 1'b0;
    chk_a_state("t3_clear", 1'b0, 1'b1, 1'b0, 2'b00, 32'd0);
    step(); step(); step(); step();
    chk("t4_restart.running", 32'(ifa.running), 32'd1);

    // T4: timeout with PC changing every cycle
    for (int i = 0; i < 19; i++) begin
      ifa.pc = 32'(32'h100 + 4 * i);
      step();
    end
    chk_a_state("t4_pre", 1'b1, 1'b0, 1'b0, 2'b00, 32'd19);
    ifa.pc = 32'h0000_0400;
    step();
    chk_a_state("t4_timeout", 1'b0, 1'b0, 1'b1, 2'b10, 32'd20);
    for (int i = 0; i < 10; i++) begin
      ifa.pc = 32'(32'h800 + 4 * i);
      ifa.start = (i == 3);
      step();
    end
    ifa.start = 1'b0;
    chk_a_state("t4_hold", 1'b0, 1'b0, 1'b1, 2'b10, 32'd20);

    // T5a: abort, halt and timeout on the same edge
    ifa.clear = 1'b1;
    step();
    ifa.clear = 1'b0;
    step(); step(); step(); step();
    for (int i = 1; i <= 20; i++) begin
      ifa.pc = (i < 16) ? 32'(32'h200 + 4 * i) : 32'h0000_BEEF;
      ifa.abort = (i == 20);
      step();
      if (i == 19) chk("t5a_pre.done", 32'(ifa.done), 32'd0);
    end
    ifa.abort = 1'b0;
    chk_a_state("t5a_all", 1'b0, 1'b0, 1'b1, 2'b11, 32'd20);

    // T5b: halt and timeout together; abort held through IDLE/RESET_HOLD is ignored
    ifa.clear = 1'b1;
    step();
    ifa.clear = 1'b0;
    ifa.abort = 1'b1;
    step(); step(); step();
    ifa.abort = 1'b0;
    step();
    chk("t5b_start.running", 32'(ifa.running), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      ifa.pc = (i < 16) ? 32'(32'h600 + 4 * i) : 32'h0000_CAFE;
      step();
    end
    chk_a_state("t5b_halt", 1'b0, 1'b0, 1'b1, 2'b01, 32'd20);

    // T6: no auto start, start pulse, clear in DONE, async reset mid-RUN
    rst_b = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ifb.cpu_en) seen_en = 1'b1;
    end
    chk("t6_idle.seen_en", 32'(seen_en), 32'd0);
    chk("t6_idle.cpu_reset", 32'(ifb.cpu_reset), 32'd1);
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    chk("t6_hold.cpu_en", 32'(ifb.cpu_en), 32'd0);
    step();
    chk("t6_run.cpu_en", 32'(ifb.cpu_en), 32'd1);
    chk("t6_run.cpu_reset", 32'(ifb.cpu_reset), 32'd0);
    ifb.pc = 32'h10; ifb.clear = 1'b1;
    step();
    ifb.clear = 1'b0;
    chk("t6_clear_run.running", 32'(ifb.running), 32'd1);
    ifb.pc = 32'h20; ifb.abort = 1'b1;
    step();
    ifb.abort = 1'b0;
    chk("t6_abort.done", 32'(ifb.done), 32'd1);
    chk("t6_abort.status", 32'(ifb.status), 32'd3);
    chk("t6_abort.count", ifb.cycle_count, 32'd2);
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    chk("t6_start_done.done", 32'(ifb.done), 32'd1);
    ifb.clear = 1'b1;
    step();
    ifb.clear = 1'b0;
    chk("t6_clear.done", 32'(ifb.done), 32'd0);
    chk("t6_clear.status", 32'(ifb.status), 32'd0);
    chk("t6_clear.count", ifb.cycle_count, 32'd0);
    step(); step(); step();
    chk("t6_idle2.cpu_en", 32'(ifb.cpu_en), 32'd0);
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      ifb.pc = 32'(32'h40 + 4 * i);
      step();
    end
    chk("t6_mid.count", ifb.cycle_count, 32'd3);
    #2;
    rst_b = 1'b1;
    #1;
    chk("t6_async.cpu_reset", 32'(ifb.cpu_reset), 32'd1);
    chk("t6_async.running", 32'(ifb.running), 32'd0);
    chk("t6_async.count", ifb.cycle_count, 32'd0);
    step();
    rst_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
